alu_arbiter: RTL

Shares the single 8-bit ALU between two requesters: requester 0 is the CPU execute path and requester 1 is an auxiliary unit such as the branch-compare unit. The block latches one requester's operation and operands and holds them stable on the ALU inputs for a fixed settle time. It then captures RESULT/ZERO into that requester's private result registers and pulses a one-cycle acknowledge. Contention is resolved round-robin.

---
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// The grantee's operands are held on the ALU for SETTLE_CYCLES, then the result is captured and acknowledged.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 1   // legal range 1..15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic [2:0]            SEL0,
  input  logic [2:0]            SEL1,
  input  logic [DATA_WIDTH-1:0] A0,
  input  logic [DATA_WIDTH-1:0] B0,
  input  logic [DATA_WIDTH-1:0] A1,
  input  logic [DATA_WIDTH-1:0] B1,
  output logic                  ACK0,
  output logic                  ACK1,
  output logic [DATA_WIDTH-1:0] RES0,
  output logic [DATA_WIDTH-1:0] RES1,
  output logic                  ZERO0,
  output logic                  ZERO1,
  output logic [DATA_WIDTH-1:0] ALU_DATAIN1,
  output logic [DATA_WIDTH-1:0] ALU_DATAIN2,
  output logic [2:0]            ALU_SELECT,
  input  logic [DATA_WIDTH-1:0] ALU_RESULT,
  input  logic                  ALU_ZERO,
  output logic                  BUSY,
  output logic                  OWNER,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [2:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] res0_q, res0_d;
  logic [DATA_WIDTH-1:0] res1_q, res1_d;
  logic                  zero0_q, zero0_d;
  logic                  zero1_q, zero1_d;
  logic                  gnt;

  // LAST resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= 4'd0;
      sel_q   <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      zero0_q <= 1'b0;
      zero1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      zero0_q <= zero0_d;
      zero1_q <= zero1_d;
    end
  end

  // On a tie the requester that was not served last wins.
  assign gnt = (REQ0 && REQ1) ? ~last_q : REQ1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    zero0_d = zero0_q;
    zero1_d = zero1_q;
    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          state_d = S_HOLD;
          last_d  = gnt;
          owner_d = gnt;
          cnt_d   = CNT_INIT;
          sel_d   = gnt ? SEL1 : SEL0;
          a_d     = gnt ? A1 : A0;
          b_d     = gnt ? B1 : B0;
        end
      end
      S_HOLD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          if (owner_q) begin
            res1_d  = ALU_RESULT;
            zero1_d = ALU_ZERO;
          end else begin
            res0_d  = ALU_RESULT;
            zero0_d = ALU_ZERO;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ACK is decoded from DONE, so a reset during HOLD or DONE suppresses it.
  always_comb begin
    ACK0        = 1'b0;
    ACK1        = 1'b0;
    BUSY        = 1'b0;
    ALU_SELECT  = 3'd0;
    ALU_DATAIN1 = '0;
    ALU_DATAIN2 = '0;
    case (state_q)
      S_HOLD: begin
        BUSY        = 1'b1;
        ALU_SELECT  = sel_q;
        ALU_DATAIN1 = a_q;
        ALU_DATAIN2 = b_q;
      end
      S_DONE: begin
        BUSY = 1'b1;
        ACK0 = ~owner_q;
        ACK1 = owner_q;
      end
      default: ;
    endcase
  end

  assign RES0      = res0_q;
  assign RES1      = res1_q;
  assign ZERO0     = zero0_q;
  assign ZERO1     = zero1_q;
  assign OWNER     = owner_q;
  assign dbg_state = state_q;

endmodule
